cache_tag_ctrl: RTL and testbench

- Lookup/refill controller for the 2-way set-associative data cache; master side of the 45-bit tag RAM interface.
- Drives tag RAM read/write address, write enables and write data, and consumes tag RAM read data.
- Sequences power-on tag clear, hit detection with LRU/dirty update, and victim selection.
- Issues miss/writeback requests to the memory-side refill engine.

---
 rtl/cache_tag_ctrl_if.sv | 51 +++++
 rtl/cache_tag_ctrl.sv | 173 +++++++++++++++++
 tb/tb_cache_tag_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_tag_ctrl_if.sv
// Request, tag RAM and refill-engine signals of the tag controller.
// master = controller view, slave = environment view.
interface cache_tag_ctrl_if #(
    parameter int IDX_W = 7,
    parameter int TAG_W = 20
);
    localparam int DW = 2 * (TAG_W + 2) + 1;

    logic             req_valid;
    logic [31:0]      req_addr;
    logic             req_wr;
    logic             req_ready;
    logic             resp_valid;
    logic             resp_hit;
    logic             resp_way;
    logic [IDX_W-1:0] tr_raddr;
    logic             tr_re;
    logic [IDX_W-1:0] tr_waddr;
    logic [1:0]       tr_we;
    logic [DW-1:0]    tr_din;
    logic [DW-1:0]    tr_dout;
    logic             tr_refill;
    logic             tr_load_over;
    logic             tr_cache_reset;
    logic             miss_req_valid;
    logic             miss_req_ready;
    logic [31:0]      miss_req_addr;
    logic             miss_req_wb;
    logic [31:0]      miss_wb_addr;
    logic             refill_done;

    modport master (
        input  req_valid, req_addr, req_wr, tr_dout,
        input  miss_req_ready, refill_done,
        output req_ready, resp_valid, resp_hit, resp_way,
        output tr_raddr, tr_re, tr_waddr, tr_we, tr_din,
        output tr_refill, tr_load_over, tr_cache_reset,
        output miss_req_valid, miss_req_addr, miss_req_wb,
        output miss_wb_addr
    );

    modport slave (
        output req_valid, req_addr, req_wr, tr_dout,
        output miss_req_ready, refill_done,
        input  req_ready, resp_valid, resp_hit, resp_way,
        input  tr_raddr, tr_re, tr_waddr, tr_we, tr_din,
        input  tr_refill, tr_load_over, tr_cache_reset,
        input  miss_req_valid, miss_req_addr, miss_req_wb,
        input  miss_wb_addr
    );
endinterface

// File: rtl/cache_tag_ctrl.sv
// 2-way set-associative tag lookup/refill controller (tag RAM master).
// Optional hit/miss counters when CACHE_TAG_PERF_CNT_EN is defined.
module cache_tag_ctrl #(
    parameter int IDX_W = 7,
    parameter int OFF_W = 5,
    parameter int TAG_W = 20
) (
    input logic clk,
    input logic rst,
    cache_tag_ctrl_if.master bus
`ifdef CACHE_TAG_PERF_CNT_EN
    ,
    output logic [31:0] perf_hit_cnt,
    output logic [31:0] perf_miss_cnt
`endif
);
    localparam int WB = TAG_W + 2;
    localparam int LRU_B = 2 * WB;
    localparam int DW = 2 * WB + 1;
    localparam logic [IDX_W:0] INIT_LAST = {1'b0, {IDX_W{1'b1}}};

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_LOOKUP, S_UPDATE,
        S_MISS_REQ, S_WAIT_REFILL, S_REFILL_WR
    } state_t;

    state_t           state;
    logic [IDX_W:0]   init_cnt;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] lk_idx;
    logic             lk_wr;
    logic             victim;
    logic             accept;
    logic [TAG_W-1:0] tag0, tag1;
    logic             v0, v1, d0, d1, lru;
    logic             hit0, hit1, vic;
    logic [DW-1:0]    upd_din, ref_din;
    logic [WB-1:0]    new_way;

    assign accept = bus.req_valid && bus.req_ready;
    assign bus.tr_re = accept;
    assign bus.tr_raddr = accept ? bus.req_addr[OFF_W +: IDX_W] : '0;

    always_comb begin
        tag0 = bus.tr_dout[0 +: TAG_W];
        v0   = bus.tr_dout[TAG_W];
        d0   = bus.tr_dout[TAG_W+1];
        tag1 = bus.tr_dout[WB +: TAG_W];
        v1   = bus.tr_dout[WB+TAG_W];
        d1   = bus.tr_dout[WB+TAG_W+1];
        lru  = bus.tr_dout[LRU_B];
        // A double hit is illegal; way0 takes it.
        hit0 = v0 && (tag0 == lk_tag);
        hit1 = v1 && (tag1 == lk_tag) && !hit0;
        if (!v0)      vic = 1'b0;
        else if (!v1) vic = 1'b1;
        else          vic = lru;
        upd_din = bus.tr_dout;
        upd_din[LRU_B] = ~hit1;
        if (hit1) upd_din[WB+TAG_W+1] = d1 | lk_wr;
        else      upd_din[TAG_W+1]    = d0 | lk_wr;
        new_way = {lk_wr, 1'b1, lk_tag};
        ref_din = '0;
        ref_din[LRU_B] = ~victim;
        if (victim) ref_din[WB +: WB] = new_way;
        else        ref_din[0 +: WB]  = new_way;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= S_INIT;
            init_cnt           <= '0;
            lk_tag             <= '0;
            lk_idx             <= '0;
            lk_wr              <= 1'b0;
            victim             <= 1'b0;
            bus.req_ready      <= 1'b0;
            bus.resp_valid     <= 1'b0;
            bus.resp_hit       <= 1'b0;
            bus.resp_way       <= 1'b0;
            bus.tr_waddr       <= '0;
            bus.tr_we          <= 2'b00;
            bus.tr_din         <= '0;
            bus.tr_refill      <= 1'b0;
            bus.tr_load_over   <= 1'b0;
            bus.tr_cache_reset <= 1'b0;
            bus.miss_req_valid <= 1'b0;
            bus.miss_req_addr  <= '0;
            bus.miss_req_wb    <= 1'b0;
            bus.miss_wb_addr   <= '0;
        end else begin
            bus.resp_valid   <= 1'b0;
            bus.resp_hit     <= 1'b0;
            bus.resp_way     <= 1'b0;
            bus.tr_we        <= 2'b00;
            bus.tr_refill    <= 1'b0;
            bus.tr_load_over <= 1'b0;
            case (state)
                S_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == INIT_LAST) begin
                        state              <= S_IDLE;
                        bus.tr_cache_reset <= 1'b1;
                        bus.req_ready      <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (accept) begin
                        lk_tag        <= bus.req_addr[OFF_W+IDX_W +: TAG_W];
                        lk_idx        <= bus.req_addr[OFF_W +: IDX_W];
                        lk_wr         <= bus.req_wr;
                        bus.req_ready <= 1'b0;
                        state         <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit0 || hit1) begin
                        bus.resp_valid   <= 1'b1;
                        bus.resp_hit     <= 1'b1;
                        bus.resp_way     <= hit1;
                        bus.tr_waddr     <= lk_idx;
                        bus.tr_we        <= hit1 ? 2'b10 : 2'b01;
                        bus.tr_din       <= upd_din;
                        bus.tr_load_over <= 1'b1;
                        state            <= S_UPDATE;
                    end else begin
                        victim             <= vic;
                        bus.miss_req_valid <= 1'b1;
                        bus.miss_req_addr  <= {lk_tag, lk_idx, {OFF_W{1'b0}}};
                        bus.miss_req_wb    <= vic ? (v1 && d1) : (v0 && d0);
                        bus.miss_wb_addr   <= {vic ? tag1 : tag0, lk_idx,
                                               {OFF_W{1'b0}}};
                        state              <= S_MISS_REQ;
                    end
                end
                S_MISS_REQ: begin
                    if (bus.miss_req_ready) begin
                        bus.miss_req_valid <= 1'b0;
                        state              <= S_WAIT_REFILL;
                    end
                end
                S_WAIT_REFILL: begin
                    if (bus.refill_done) begin
                        bus.resp_valid <= 1'b1;
                        bus.resp_way   <= victim;
                        bus.tr_waddr   <= lk_idx;
                        bus.tr_we      <= victim ? 2'b10 : 2'b01;
                        bus.tr_din     <= ref_din;
                        bus.tr_refill  <= 1'b1;
                        state          <= S_REFILL_WR;
                    end
                end
                S_UPDATE, S_REFILL_WR: begin
                    bus.req_ready <= 1'b1;
                    state         <= S_IDLE;
                end
                default: state <= S_INIT;
            endcase
        end
    end

`ifdef CACHE_TAG_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_hit_cnt  <= '0;
            perf_miss_cnt <= '0;
        end else if (bus.resp_valid) begin
            if (bus.resp_hit) perf_hit_cnt  <= perf_hit_cnt + 32'd1;
            else              perf_miss_cnt <= perf_miss_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Bench for cache_tag_ctrl: tag RAM model, refill responder, cache model.
// Directed scenarios followed by randomized accesses.
module tb_cache_tag_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_tag_ctrl_if #(.IDX_W(7), .TAG_W(20)) bus ();
`ifdef CACHE_TAG_PERF_CNT_EN
    logic [31:0] perf_hit_cnt, perf_miss_cnt;
`endif

    cache_tag_ctrl #(.IDX_W(7), .OFF_W(5), .TAG_W(20)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef CACHE_TAG_PERF_CNT_EN
        ,
        .perf_hit_cnt(perf_hit_cnt),
        .perf_miss_cnt(perf_miss_cnt)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;
    int n_stray = 0;
    int hits_n = 0;
    int miss_n = 0;

    // Tag RAM: synchronous read, per-way masked write, bulk clear.
    logic [44:0] ram [128];
    always @(posedge clk) begin
        if (!bus.tr_cache_reset) begin
            for (int i = 0; i < 128; i++) ram[i] <= '0;
        end else if (bus.tr_we != 2'b00) begin
            ram[bus.tr_waddr][44] <= bus.tr_din[44];
            if (bus.tr_we[0]) begin
                ram[bus.tr_waddr][21] <= bus.tr_din[21];
                if (bus.tr_refill)
                    ram[bus.tr_waddr][20:0] <= bus.tr_din[20:0];
            end
            if (bus.tr_we[1]) begin
                ram[bus.tr_waddr][43] <= bus.tr_din[43];
                if (bus.tr_refill)
                    ram[bus.tr_waddr][42:22] <= bus.tr_din[42:22];
            end
        end
        if (bus.tr_re) bus.tr_dout <= ram[bus.tr_raddr];
    end

    always @(negedge clk)
        if (bus.tr_we !== 2'b00 && bus.resp_valid !== 1'b1)
            n_stray <= n_stray + 1;

    logic        o_resp, o_hit, o_way, o_miss, o_wb, o_stable;
    logic        o_lo, o_rf, o_re;
    logic [6:0]  o_raddr;
    logic [1:0]  o_we;
    logic [44:0] o_din;
    logic [31:0] o_maddr, o_wbaddr;
    int          o_lat;

    task automatic run_access(input logic [31:0] a, input logic wr,
                              input int rdy_dly, input int done_dly);
        int stall;
        int wcnt;
        o_resp = 0; o_miss = 0; o_stable = 1; o_lat = 0;
        o_hit = 0; o_way = 0; o_wb = 0;
        stall = 0; wcnt = 0;
        for (int k = 0; k < 300 && bus.req_ready !== 1'b1; k++)
            @(negedge clk);
        bus.req_valid = 1; bus.req_addr = a; bus.req_wr = wr;
        #1;
        o_re = bus.tr_re; o_raddr = bus.tr_raddr;
        @(negedge clk);
        bus.req_valid = 0; bus.req_addr = $urandom; bus.req_wr = 1'($urandom);
        for (int c = 1; c < 400 && !o_resp; c++) begin
            bus.refill_done = 0;
            if (bus.resp_valid === 1'b1) begin
                o_resp = 1; o_lat = c;
                o_hit = bus.resp_hit; o_way = bus.resp_way;
                o_we = bus.tr_we; o_din = bus.tr_din;
                o_lo = bus.tr_load_over; o_rf = bus.tr_refill;
            end else if (bus.miss_req_valid === 1'b1) begin
                if (!o_miss) begin
                    o_miss = 1; o_maddr = bus.miss_req_addr;
                    o_wb = bus.miss_req_wb; o_wbaddr = bus.miss_wb_addr;
                end else if (bus.miss_req_addr !== o_maddr ||
                             bus.miss_req_wb !== o_wb ||
                             bus.miss_wb_addr !== o_wbaddr) begin
                    o_stable = 0;
                end
                bus.miss_req_ready = (stall >= rdy_dly);
                stall++;
            end else if (o_miss) begin
                bus.miss_req_ready = 0;
                if (wcnt == done_dly) bus.refill_done = 1;
                wcnt++;
            end
            if (!o_resp) @(negedge clk);
        end
        bus.miss_req_ready = 0; bus.refill_done = 0;
    endtask

    task automatic test_reset();
        int cnt;
        rst = 1;
        repeat (3) @(negedge clk);
        n_vec++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_req_ready: got %b want 0", bus.req_ready); end
        n_vec++; if (bus.tr_cache_reset !== 1'b0) begin n_bad++; $display("FAIL rst_cache_reset: got %b want 0", bus.tr_cache_reset); end
        n_vec++; if (bus.miss_req_valid !== 1'b0 || bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valids: got %b%b want 00", bus.miss_req_valid, bus.resp_valid); end
        n_vec++; if (bus.tr_we !== 2'b00 || bus.tr_re !== 1'b0) begin n_bad++; $display("FAIL rst_ram_en: got we=%b re=%b want 0", bus.tr_we, bus.tr_re); end
        rst = 0;
        cnt = 0;
        while (bus.tr_cache_reset === 1'b0 && cnt < 300) begin
            if (bus.req_ready !== 1'b0) begin
                n_vec++; n_bad++;
                $display("FAIL init_req_ready: got %b want 0 at %0d", bus.req_ready, cnt);
            end
            cnt++;
            @(negedge clk);
        end
        n_vec++; if (cnt != 128) begin n_bad++; $display("FAIL init_len: got %0d want 128", cnt); end
        n_vec++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL init_done_ready: got %b want 1", bus.req_ready); end
    endtask

    task automatic test_miss_refill();
        run_access(32'h0000_1040, 1'b0, 0, 0);
        n_vec++; if (o_re !== 1'b1 || o_raddr !== 7'd2) begin n_bad++; $display("FAIL mr_read: got re=%b idx=%h want 1/02", o_re, o_raddr); end
        n_vec++; if (o_resp !== 1'b1 || o_miss !== 1'b1) begin n_bad++; $display("FAIL mr_seen: got resp=%b miss=%b want 11", o_resp, o_miss); end
        n_vec++; if (o_maddr !== 32'h0000_1040) begin n_bad++; $display("FAIL mr_addr: got %h want 00001040", o_maddr); end
        n_vec++; if (o_wb !== 1'b0) begin n_bad++; $display("FAIL mr_wb: got %b want 0", o_wb); end
        n_vec++; if (o_hit !== 1'b0 || o_way !== 1'b0) begin n_bad++; $display("FAIL mr_resp: got hit=%b way=%b want 0/0", o_hit, o_way); end
        n_vec++; if (o_we !== 2'b01 || o_rf !== 1'b1 || o_lo !== 1'b0) begin n_bad++; $display("FAIL mr_wr: got we=%b rf=%b lo=%b want 01/1/0", o_we, o_rf, o_lo); end
        n_vec++; if (o_din[20:0] !== 21'h100001) begin n_bad++; $display("FAIL mr_way0: got %h want 100001", o_din[20:0]); end
        n_vec++; if (o_din[44] !== 1'b1 || o_din[21] !== 1'b0) begin n_bad++; $display("FAIL mr_lru_dirty: got %b%b want 10", o_din[44], o_din[21]); end
    endtask

    task automatic test_hit();
        run_access(32'h0000_1044, 1'b1, 0, 0);
        n_vec++; if (o_resp !== 1'b1 || o_lat != 2) begin n_bad++; $display("FAIL hit_lat: got %0d want 2", o_lat); end
        n_vec++; if (o_hit !== 1'b1 || o_way !== 1'b0 || o_miss !== 1'b0) begin n_bad++; $display("FAIL hit_resp: got hit=%b way=%b miss=%b want 1/0/0", o_hit, o_way, o_miss); end
        n_vec++; if (o_we !== 2'b01 || o_lo !== 1'b1 || o_rf !== 1'b0) begin n_bad++; $display("FAIL hit_wr: got we=%b lo=%b rf=%b want 01/1/0", o_we, o_lo, o_rf); end
        n_vec++; if (o_din[21] !== 1'b1 || o_din[44] !== 1'b1) begin n_bad++; $display("FAIL hit_din: got d0=%b lru=%b want 1/1", o_din[21], o_din[44]); end
    endtask

    task automatic test_victim_wb();
        run_access(32'h0000_2040, 1'b0, 1, 2);
        n_vec++; if (o_hit !== 1'b0 || o_way !== 1'b1 || o_wb !== 1'b0) begin n_bad++; $display("FAIL fill1: got hit=%b way=%b wb=%b want 0/1/0", o_hit, o_way, o_wb); end
        n_vec++; if (o_we !== 2'b10 || o_din[42:22] !== 21'h100002) begin n_bad++; $display("FAIL fill1_din: got we=%b f=%h want 10/100002", o_we, o_din[42:22]); end
        n_vec++; if (o_din[44] !== 1'b0 || o_din[43] !== 1'b0) begin n_bad++; $display("FAIL fill1_lru: got %b%b want 00", o_din[44], o_din[43]); end
        run_access(32'h0000_3040, 1'b0, 5, 1);
        n_vec++; if (o_miss !== 1'b1 || o_maddr !== 32'h0000_3040) begin n_bad++; $display("FAIL vic_addr: got %h want 00003040", o_maddr); end
        n_vec++; if (o_wb !== 1'b1 || o_wbaddr !== 32'h0000_1040) begin n_bad++; $display("FAIL vic_wb: got wb=%b a=%h want 1/00001040", o_wb, o_wbaddr); end
        n_vec++; if (o_stable !== 1'b1) begin n_bad++; $display("FAIL vic_stable: got %b want 1", o_stable); end
        n_vec++; if (o_way !== 1'b0 || o_hit !== 1'b0) begin n_bad++; $display("FAIL vic_way: got way=%b hit=%b want 0/0", o_way, o_hit); end
        run_access(32'h0000_205C, 1'b1, 0, 0);
        n_vec++; if (o_hit !== 1'b1 || o_way !== 1'b1 || o_we !== 2'b10) begin n_bad++; $display("FAIL hit1: got hit=%b way=%b we=%b want 1/1/10", o_hit, o_way, o_we); end
        n_vec++; if (o_din[43] !== 1'b1 || o_din[44] !== 1'b0) begin n_bad++; $display("FAIL hit1_din: got d1=%b lru=%b want 1/0", o_din[43], o_din[44]); end
    endtask

    task automatic test_stall_reset();
        logic [31:0] a0;
        logic stable;
        int k;
        for (k = 0; k < 300 && bus.req_ready !== 1'b1; k++) @(negedge clk);
        bus.req_valid = 1; bus.req_addr = 32'h0000_4040; bus.req_wr = 0;
        @(negedge clk);
        bus.req_valid = 0;
        for (k = 0; k < 20 && bus.miss_req_valid !== 1'b1; k++) @(negedge clk);
        n_vec++; if (bus.miss_req_valid !== 1'b1) begin n_bad++; $display("FAIL sr_miss: got %b want 1", bus.miss_req_valid); end
        a0 = bus.miss_req_addr;
        stable = 1;
        repeat (5) begin
            bus.miss_req_ready = 0;
            @(negedge clk);
            if (bus.miss_req_valid !== 1'b1 || bus.miss_req_addr !== a0) stable = 0;
        end
        n_vec++; if (a0 !== 32'h0000_4040 || stable !== 1'b1) begin n_bad++; $display("FAIL sr_hold: got a=%h st=%b want 00004040/1", a0, stable); end
        rst = 1;
        @(negedge clk);
        n_vec++; if (bus.miss_req_valid !== 1'b0) begin n_bad++; $display("FAIL sr_drop: got %b want 0", bus.miss_req_valid); end
        n_vec++; if (bus.req_ready !== 1'b0 || bus.tr_cache_reset !== 1'b0) begin n_bad++; $display("FAIL sr_init: got rdy=%b cr=%b want 0/0", bus.req_ready, bus.tr_cache_reset); end
        rst = 0;
        for (k = 0; k < 300 && bus.req_ready !== 1'b1; k++) @(negedge clk);
        n_vec++; if (bus.req_ready !== 1'b1 || k < 100) begin n_bad++; $display("FAIL sr_reinit: got rdy=%b after %0d want 1 after 128", bus.req_ready, k); end
    endtask

    task automatic test_random(input int n);
        logic        mv [4][2];
        logic        md [4][2];
        logic [19:0] mt [4][2];
        logic        mlru [4];
        logic [6:0]  sets [4];
        logic [19:0] tags [4];
        sets[0] = 7'd0; sets[1] = 7'd1; sets[2] = 7'd64; sets[3] = 7'd127;
        tags[0] = 20'h0; tags[1] = 20'h1; tags[2] = 20'h2; tags[3] = 20'hFFFFF;
        for (int s = 0; s < 4; s++) begin
            mlru[s] = 0;
            for (int w = 0; w < 2; w++) begin mv[s][w] = 0; md[s][w] = 0; mt[s][w] = '0; end
        end
        for (int i = 0; i < n; i++) begin
            int s, h, v;
            logic [19:0] tg;
            logic wr, ewb;
            logic [31:0] a;
            s = $urandom_range(0, 3);
            tg = tags[$urandom_range(0, 3)];
            wr = 1'($urandom);
            a = {tg, sets[s], 5'($urandom_range(0, 31))};
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk); bus.refill_done = 1;
                @(negedge clk); bus.refill_done = 0;
            end
            run_access(a, wr, $urandom_range(0, 3), $urandom_range(0, 3));
            h = -1;
            if (mv[s][0] && mt[s][0] == tg) h = 0;
            else if (mv[s][1] && mt[s][1] == tg) h = 1;
            n_vec++; if (o_resp !== 1'b1 || o_re !== 1'b1 || o_raddr !== sets[s]) begin n_bad++; $display("FAIL rnd_acc %0d: got resp=%b re=%b idx=%h want 1/1/%h", i, o_resp, o_re, o_raddr, sets[s]); end
            n_vec++; if (o_hit !== (h >= 0)) begin n_bad++; $display("FAIL rnd_hit %0d: got %b want %b", i, o_hit, h >= 0); end
            if (h >= 0) begin
                hits_n++;
                n_vec++; if (o_way !== 1'(h) || o_lat != 2 || o_miss !== 1'b0) begin n_bad++; $display("FAIL rnd_hitway %0d: got way=%b lat=%0d want %0d/2", i, o_way, o_lat, h); end
                md[s][h] = md[s][h] | wr;
                mlru[s] = (h == 0);
            end else begin
                miss_n++;
                v = !mv[s][0] ? 0 : !mv[s][1] ? 1 : int'(mlru[s]);
                ewb = mv[s][v] && md[s][v];
                n_vec++; if (o_way !== 1'(v) || o_maddr !== {tg, sets[s], 5'd0}) begin n_bad++; $display("FAIL rnd_miss %0d: got way=%b a=%h want %0d/%h", i, o_way, o_maddr, v, {tg, sets[s], 5'd0}); end
                n_vec++; if (o_wb !== ewb || o_stable !== 1'b1) begin n_bad++; $display("FAIL rnd_wb %0d: got wb=%b st=%b want %b/1", i, o_wb, o_stable, ewb); end
                if (ewb) begin
                    n_vec++; if (o_wbaddr !== {mt[s][v], sets[s], 5'd0}) begin n_bad++; $display("FAIL rnd_wbaddr %0d: got %h want %h", i, o_wbaddr, {mt[s][v], sets[s], 5'd0}); end
                end
                mv[s][v] = 1; mt[s][v] = tg; md[s][v] = wr;
                mlru[s] = (v == 0);
            end
        end
        repeat (3) @(negedge clk);
        n_vec++; if (n_stray != 0) begin n_bad++; $display("FAIL stray_we: got %0d want 0", n_stray); end
    endtask

`ifdef CACHE_TAG_PERF_CNT_EN
    task automatic test_perf();
        n_vec++; if (perf_hit_cnt !== 32'(hits_n)) begin n_bad++; $display("FAIL perf_hit: got %0d want %0d", perf_hit_cnt, hits_n); end
        n_vec++; if (perf_miss_cnt !== 32'(miss_n)) begin n_bad++; $display("FAIL perf_miss: got %0d want %0d", perf_miss_cnt, miss_n); end
    endtask
`endif

    initial begin
        bus.req_valid = 0; bus.req_addr = '0; bus.req_wr = 0;
        bus.miss_req_ready = 0; bus.refill_done = 0;
        test_reset();
        test_miss_refill();
        test_hit();
        test_victim_wb();
        test_stall_reset();
        test_random(200);
`ifdef CACHE_TAG_PERF_CNT_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
